// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apu_pkg
// Brief    : NR12 field layout and envelope types shared by the APU envelopes.
// Revision : 1.0
// ============================================================================
package apu_pkg;

  localparam int NR12_VOL_MSB = 7;
  localparam int NR12_VOL_LSB = 4;
  localparam int NR12_DIR     = 3;
  localparam int NR12_PER_MSB = 2;

  localparam int VOL_MAX = 15;

  typedef enum logic {
    ENV_DOWN = 1'b0,
    ENV_UP   = 1'b1
  } env_dir_t;

endpackage : apu_pkg
`default_nettype wire

// File: rtl/ch1_envelope.sv
`default_nettype none
// ============================================================================
// Module   : ch1_envelope
// Brief    : NR12-driven volume envelope (reused for channels 2 and 4).
// Revision : 1.0
// ============================================================================
module ch1_envelope
  import apu_pkg::*;
#(
  parameter int VOL_W = 4,
  parameter int PER_W = 3
) (
  input  logic             dyfa_1mhz,
  input  logic             napu_reset,
  input  logic             ch1_restart,
  input  logic             env_tick,
  input  logic [7:0]       ff12_d,
  output logic [VOL_W-1:0] ch1_env_vol,
  output logic             ch1_dac_en,
  output logic             ch1_env_done
);

  localparam logic [VOL_W-1:0] c_vol_max  = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] c_vol_zero = '0;
  localparam logic [PER_W-1:0] c_per_one  = PER_W'(1);
  localparam logic [PER_W-1:0] c_per_zero = '0;

  logic [VOL_W-1:0] r_vol;
  logic [PER_W-1:0] r_per_cnt;
  logic             r_done;

  logic [VOL_W-1:0] w_init_vol;
  logic [PER_W-1:0] w_period;
  env_dir_t         w_dir;
  logic [VOL_W-1:0] w_step_vol;
  logic             w_step_done;
  logic             w_run;

  assign w_init_vol = ff12_d[NR12_VOL_MSB -: VOL_W];
  assign w_period   = ff12_d[NR12_PER_MSB -: PER_W];
  assign w_dir      = env_dir_t'(ff12_d[NR12_DIR]);

  // A zero period freezes the envelope entirely, even the period counter.
  assign w_run = env_tick && (w_period != c_per_zero) && !r_done;

  // Saturating volume step; hitting a rail latches done instead of wrapping.
  always_comb begin
    w_step_vol  = r_vol;
    w_step_done = 1'b0;
    if (w_dir == ENV_UP) begin
      if (r_vol < c_vol_max) w_step_vol = r_vol + VOL_W'(1);
      else                   w_step_done = 1'b1;
    end else begin
      if (r_vol > c_vol_zero) w_step_vol = r_vol - VOL_W'(1);
      else                    w_step_done = 1'b1;
    end
  end

  always_ff @(posedge dyfa_1mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      r_vol     <= '0;
      r_per_cnt <= '0;
      r_done    <= 1'b0;
    end else if (ch1_restart) begin
      r_vol     <= w_init_vol;
      r_per_cnt <= w_period;
      r_done    <= 1'b0;
    end else if (w_run) begin
      if (r_per_cnt > c_per_one) begin
        r_per_cnt <= r_per_cnt - c_per_one;
      end else begin
        r_per_cnt <= w_period;
        r_vol     <= w_step_vol;
        r_done    <= w_step_done;
      end
    end
  end

  assign ch1_env_vol  = r_vol;
  assign ch1_env_done = r_done;
  assign ch1_dac_en   = |ff12_d[NR12_VOL_MSB:NR12_DIR];

endmodule : ch1_envelope
`default_nettype wire

// File: tb/tb_ch1_envelope.sv
`default_nettype none
// ============================================================================
// Module   : tb_ch1_envelope
// Brief    : Directed self-checking bench for ch1_envelope with a tick-count model.
// Revision : 1.0
// ============================================================================
module tb_ch1_envelope;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] ff12 = 8'h00;
  logic [3:0] env_vol;
  logic       dac_en;
  logic       env_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  ch1_envelope dut (
    .dyfa_1mhz   (clk),
    .napu_reset  (rst_n),
    .ch1_restart (restart),
    .env_tick    (tick),
    .ff12_d      (ff12),
    .ch1_env_vol (env_vol),
    .ch1_dac_en  (dac_en),
    .ch1_env_done(env_done)
  );

  // Model: count ticks since the last step and step once the target is met.
  int m_vol, m_seen, m_target;
  bit m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vol = 0; m_done = 0; m_seen = 0; m_target = 1;
    end else if (restart) begin
      m_vol = ff12[7:4]; m_done = 0; m_seen = 0;
      m_target = (ff12[2:0] == 0) ? 1 : int'(ff12[2:0]);
    end else if (tick && ff12[2:0] != 0 && !m_done) begin
      m_seen++;
      if (m_seen >= m_target) begin
        m_seen = 0;
        m_target = ff12[2:0];
        if (ff12[3] && m_vol < 15)       m_vol++;
        else if (!ff12[3] && m_vol > 0)  m_vol--;
        else                              m_done = 1;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      check("model_vol",  {4'd0, env_vol}, 8'(m_vol));
      check("model_done", {7'd0, env_done}, {7'd0, m_done});
      check("model_dac",  {7'd0, dac_en}, {7'd0, |ff12[7:3]});
    end
  end

  task automatic pulse_restart();
    @(posedge clk); #2 restart = 1'b1;
    @(posedge clk); #2 restart = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2 tick = 1'b1;
      @(posedge clk); #2 tick = 1'b0;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset_vol", {4'd0, env_vol}, 8'd0);
    check("reset_done", {7'd0, env_done}, 8'd0);
    #1 rst_n = 1'b1;
    cmp_on = 1'b1;

    // Down from 15 with period 3.
    ff12 = 8'hF3;
    pulse_restart();
    check("f3_trig_vol", {4'd0, env_vol}, 8'd15);
    ticks(3); check("f3_t3_vol", {4'd0, env_vol}, 8'd14);
    ticks(3); check("f3_t6_vol", {4'd0, env_vol}, 8'd13);
    ticks(3); check("f3_t9_vol", {4'd0, env_vol}, 8'd12);
    check("f3_dac", {7'd0, dac_en}, 8'd1);

    // Up from 2 with period 1 until saturation.
    ff12 = 8'h29;
    pulse_restart();
    check("29_trig_vol", {4'd0, env_vol}, 8'd2);
    ticks(1);  check("29_t1_vol", {4'd0, env_vol}, 8'd3);
    ticks(12); check("29_t13_vol", {4'd0, env_vol}, 8'd15);
    check("29_t13_done", {7'd0, env_done}, 8'd0);
    ticks(1);  check("29_t14_done", {7'd0, env_done}, 8'd1);
    ticks(6);  check("29_t20_vol", {4'd0, env_vol}, 8'd15);

    // Period 0 freezes the envelope.
    ff12 = 8'h10;
    pulse_restart();
    ticks(10);
    check("10_vol", {4'd0, env_vol}, 8'd1);
    check("10_done", {7'd0, env_done}, 8'd0);
    @(posedge clk); #2 ff12 = 8'h07;
    #1 check("07_dac_off", {7'd0, dac_en}, 8'd0);

    // Trigger wins over a simultaneous tick.
    @(posedge clk); #2 ff12 = 8'h51; restart = 1'b1; tick = 1'b1;
    @(posedge clk); #2 restart = 1'b0; tick = 1'b0;
    check("51_trig_vol", {4'd0, env_vol}, 8'd5);
    ticks(1); check("51_t1_vol", {4'd0, env_vol}, 8'd4);

    // Direction flip mid-envelope, then asynchronous reset.
    ff12 = 8'h9A;
    pulse_restart();
    @(posedge clk); #2 ff12 = 8'h0A;
    ticks(2); check("0a_vol", {4'd0, env_vol}, 8'd10);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("async_rst_vol", {4'd0, env_vol}, 8'd0);
    check("async_rst_done", {7'd0, env_done}, 8'd0);
    #1 rst_n = 1'b1;

    // Down-tick at volume 0 after reset latches done.
    @(posedge clk); #2 ff12 = 8'h02;
    ticks(1);
    check("post_rst_done", {7'd0, env_done}, 8'd1);
    check("post_rst_vol", {4'd0, env_vol}, 8'd0);

    repeat (3) @(posedge clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ch1_envelope
`default_nettype wire
